sad_accum: RTL and testbench



---
 rtl/sad_accum.sv | 144 ++++++++++++++
 tb/tb_sad_accum.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_accum.sv
// Windowed sum-of-absolute-differences accumulator with a valid/ready result port.
// Optional per-window max |diff| tracking is enabled by defining SAD_MAX_TRACK_EN.
module sad_accum #(
    parameter int unsigned WIN   = 8,
    parameter int unsigned ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       diff,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic [8:0]       n,
    output logic             sat
`ifdef SAD_MAX_TRACK_EN
    ,
    output logic [8:0]       max_abs
`endif
);

    localparam int unsigned CNT_W = 9;
    localparam int unsigned EXT_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN - 1);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state, state_nx;

    logic [ACC_W-1:0] acc;
    logic             acc_sat;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             close_c;
    logic [8:0]       abs_d;
    logic [EXT_W-1:0] sum_ext;
    logic             ovf;
    logic [ACC_W-1:0] win_acc;
    logic             win_sat;
    logic [CNT_W-1:0] win_cnt;

    // Two's-complement magnitude; -256 wraps to 9'h100, which reads as 256 unsigned.
    always_comb begin
        abs_d = diff[8] ? (~diff + 9'd1) : diff;
    end

    // Window totals including the sample accepted this cycle.
    always_comb begin
        accept  = in_valid && (state == ACC);
        sum_ext = EXT_W'(acc) + EXT_W'(abs_d);
        ovf     = sum_ext[ACC_W];
        win_acc = acc;
        win_sat = acc_sat;
        win_cnt = cnt;
        if (accept) begin
            win_acc = ovf ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
            win_sat = acc_sat | ovf;
            win_cnt = cnt + CNT_W'(1);
        end
        close_c = (state == ACC) &&
                  ((accept && (cnt == LAST)) || (flush && ((cnt != '0) || accept)));
    end

`ifdef SAD_MAX_TRACK_EN
    logic [8:0] max_run;
    logic [8:0] win_max;

    always_comb begin
        win_max = max_run;
        if (accept && (abs_d > max_run)) begin
            win_max = abs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_run <= '0;
            max_abs <= '0;
        end else if (close_c) begin
            max_run <= '0;
            max_abs <= win_max;
        end else begin
            max_run <= win_max;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ACC:     if (close_c)   state_nx = HOLD;
            HOLD:    if (out_ready) state_nx = ACC;
            default: state_nx = ACC;
        endcase
    end

    // Handshake flags are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nx == ACC);
            out_valid <= (state_nx == HOLD);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            acc_sat <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            n       <= '0;
            sat     <= 1'b0;
        end else if (close_c) begin
            acc     <= '0;
            acc_sat <= 1'b0;
            cnt     <= '0;
            sum     <= win_acc;
            n       <= win_cnt;
            sat     <= win_sat;
        end else begin
            acc     <= win_acc;
            acc_sat <= win_sat;
            cnt     <= win_cnt;
        end
    end

endmodule

// File: tb/tb_sad_accum.sv
// Bench for sad_accum: two instances (WIN=8/ACC_W=12 and WIN=4/ACC_W=9) on shared inputs,
// checked against a per-instance window model, directed tables and random traffic.
module tb_sad_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [8:0] diff;
    logic       flush;
    logic       out_ready;

    logic        a_in_ready, a_out_valid, a_sat;
    logic [11:0] a_sum;
    logic [8:0]  a_n, a_max;
    logic        b_in_ready, b_out_valid, b_sat;
    logic [8:0]  b_sum;
    logic [8:0]  b_n, b_max;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sad_accum #(.WIN(8), .ACC_W(12)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .diff(diff), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
        .sum(a_sum), .n(a_n), .sat(a_sat)
`ifdef SAD_MAX_TRACK_EN
        , .max_abs(a_max)
`endif
    );

    sad_accum #(.WIN(4), .ACC_W(9)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .diff(diff), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
        .sum(b_sum), .n(b_n), .sat(b_sat)
`ifdef SAD_MAX_TRACK_EN
        , .max_abs(b_max)
`endif
    );

`ifndef SAD_MAX_TRACK_EN
    assign a_max = '0;
    assign b_max = '0;
`endif

    // Reference model: true integer sums, clipped only when a result is published.
    bit m_hold[2];
    int m_cnt[2], m_tsum[2], m_mx[2];
    int e_sum[2], e_n[2], e_max[2];
    bit e_sat[2];

    function automatic int win_of(int k);
        return (k == 0) ? 8 : 4;
    endfunction

    function automatic int lim_of(int k);
        return (k == 0) ? 4095 : 511;
    endfunction

    function automatic void model_step(int k, bit r, bit iv, int d, bit fl, bit ordy);
        int a;
        a = (d < 0) ? -d : d;
        if (r) begin
            m_hold[k] = 0; m_cnt[k] = 0; m_tsum[k] = 0; m_mx[k] = 0;
            e_sum[k] = 0; e_n[k] = 0; e_sat[k] = 0; e_max[k] = 0;
        end else if (!m_hold[k]) begin
            if (iv) begin
                m_cnt[k]++;
                m_tsum[k] += a;
                if (a > m_mx[k]) m_mx[k] = a;
            end
            if ((iv && m_cnt[k] == win_of(k)) || (fl && m_cnt[k] > 0)) begin
                e_sum[k] = (m_tsum[k] > lim_of(k)) ? lim_of(k) : m_tsum[k];
                e_sat[k] = (m_tsum[k] > lim_of(k));
                e_n[k]   = m_cnt[k];
                e_max[k] = m_mx[k];
                m_hold[k] = 1; m_cnt[k] = 0; m_tsum[k] = 0; m_mx[k] = 0;
            end
        end else if (ordy) begin
            m_hold[k] = 0;
        end
    endfunction

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    function automatic void cmp_model(int k);
        string p;
        p = (k == 0) ? "a" : "b";
        chk({p, ".in_ready"},  (k == 0) ? int'(a_in_ready)  : int'(b_in_ready),  int'(!m_hold[k]));
        chk({p, ".out_valid"}, (k == 0) ? int'(a_out_valid) : int'(b_out_valid), int'(m_hold[k]));
        chk({p, ".sum"},       (k == 0) ? int'(a_sum)       : int'(b_sum),       e_sum[k]);
        chk({p, ".n"},         (k == 0) ? int'(a_n)         : int'(b_n),         e_n[k]);
        chk({p, ".sat"},       (k == 0) ? int'(a_sat)       : int'(b_sat),       int'(e_sat[k]));
`ifdef SAD_MAX_TRACK_EN
        chk({p, ".max_abs"},   (k == 0) ? int'(a_max)       : int'(b_max),       e_max[k]);
`endif
    endfunction

    task automatic step(input bit r, input bit iv, input int d, input bit fl, input bit ordy);
        @(negedge clk);
        rst = r; in_valid = iv; diff = 9'(d); flush = fl; out_ready = ordy;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            model_step(k, r, iv, d, fl, ordy);
            cmp_model(k);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit iv;
        int d;
        bit fl;
        bit ordy;
        bit chk;
        bit e_ov;
        int e_sum;
        int e_n;
        int e_max;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit iv, int d, bit fl, bit ordy, bit c, bit ov, int s, int nn, int mx);
        vec_t v;
        v.iv = iv; v.d = d; v.fl = fl; v.ordy = ordy;
        v.chk = c; v.e_ov = ov; v.e_sum = s; v.e_n = nn; v.e_max = mx;
        tbl.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; diff = '0; flush = 1'b0; out_ready = 1'b0;

        do_reset();
        chk("reset.in_ready", int'(a_in_ready), 1);
        chk("reset.out_valid", int'(a_out_valid), 0);
        chk("reset.sum", int'(a_sum), 0);
        chk("reset.n", int'(a_n), 0);
        chk("reset.sat", int'(a_sat), 0);

        // Full window of -10, then the extremes sequence closed by flush.
        for (int i = 0; i < 6; i++) add(1, -10, 0, 1, 0, 0, 0, 0, 0);
        add(1, -10, 0, 1, 1, 0, 0, 0, 0);
        add(1, -10, 0, 1, 1, 1, 80, 8, 10);
        add(0, 0, 0, 1, 1, 0, 80, 8, 10);
        add(1, 255, 0, 1, 0, 0, 0, 0, 0);
        add(1, -256, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, -1, 1, 1, 1, 1, 512, 4, 256);
        add(0, 0, 0, 1, 1, 0, 512, 4, 256);

        foreach (tbl[i]) begin
            step(1'b0, tbl[i].iv, tbl[i].d, tbl[i].fl, tbl[i].ordy);
            if (tbl[i].chk) begin
                chk("tbl.out_valid", int'(a_out_valid), int'(tbl[i].e_ov));
                chk("tbl.in_ready", int'(a_in_ready), int'(!tbl[i].e_ov));
                if (tbl[i].e_n != 0) begin
                    chk("tbl.sum", int'(a_sum), tbl[i].e_sum);
                    chk("tbl.n", int'(a_n), tbl[i].e_n);
`ifdef SAD_MAX_TRACK_EN
                    chk("tbl.max_abs", int'(a_max), tbl[i].e_max);
`endif
                end
            end
        end

        // Saturation on the narrow instance, then a clean window.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, -200, 1'b0, 1'b1);
        chk("sat.sum", int'(b_sum), 511);
        chk("sat.sat", int'(b_sat), 1);
        chk("sat.n", int'(b_n), 4);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1, 1'b0, 1'b1);
        chk("sat.next_sum", int'(b_sum), 4);
        chk("sat.next_sat", int'(b_sat), 0);

        // Back-pressure: hold result for 5 cycles while samples are offered.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 7, 1'b1, 1'b0);
            chk("bp.out_valid", int'(a_out_valid), 1);
            chk("bp.in_ready", int'(a_in_ready), 0);
            chk("bp.sum", int'(a_sum), 24);
            chk("bp.n", int'(a_n), 8);
        end
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        chk("bp.release_ready", int'(a_in_ready), 1);
        chk("bp.release_valid", int'(a_out_valid), 0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1, 1'b0, 1'b1);
        chk("bp.no_early_close", int'(a_out_valid), 0);
        step(1'b0, 1'b1, 1, 1'b0, 1'b1);
        chk("bp.next_n", int'(a_n), 8);
        chk("bp.next_sum", int'(a_sum), 8);

        // Flush with an empty window produces nothing.
        do_reset();
        step(1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk("flush_empty.out_valid", int'(a_out_valid), 0);

        // Reset mid-window discards the partial sum.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1, 1'b0, 1'b1);
        chk("rst_mid.sum", int'(a_sum), 8);
        chk("rst_mid.n", int'(a_n), 8);

        // Reset during HOLD drops out_valid.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 2, 1'b0, 1'b0);
        chk("rst_hold.pre", int'(a_out_valid), 1);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        chk("rst_hold.out_valid", int'(a_out_valid), 0);
        chk("rst_hold.sum", int'(a_sum), 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 511)) - 256,
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
